// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and helpers for the MIPS memory-stage controllers
`timescale 1ns/1ps
package mips_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;
    localparam int WORD_BITS  = 32;
    localparam int HALF_BITS  = 16;
    localparam int WORD_BYTES = 4;

    // Word index relative to the SRAM window; the low two byte-address bits drop out.
    function automatic logic [31:0] word_offset(input logic [31:0] byte_addr,
                                                input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// rtl/sram_wait_cnt.sv - wait-state counter with load-zero, increment and terminal flag
`timescale 1ns/1ps
module sram_wait_cnt #(
    parameter int unsigned MAX_VAL = 1,
    parameter int unsigned CW      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt_d,
    output logic          term
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_VAL);

    logic [CW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == MAX_C);

endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - splits MEM-stage word loads/stores into two 16-bit SRAM accesses
`timescale 1ns/1ps
module sram_mem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_En,
    input  logic               MEM_W_En,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_val,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_o,
    output logic               SRAM_DQ_oe,
    input  logic [15:0]        SRAM_DQ_i,
    output logic               SRAM_WE_N
);

    localparam int            CW     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int            WW     = SRAM_AW - 1;
    localparam logic [CW-1:0] WAIT_C = CW'(WAIT_CYCLES);

    logic [1:0]         state_q, state_d;
    logic               op_store_q, op_store_d;
    logic [WW-1:0]      word_q, word_d;
    logic [31:0]        st_val_q, st_val_d;
    logic [15:0]        lo_buf_q, lo_buf_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_o_q, dq_o_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;

    logic               req;
    logic               in_half;
    logic               cnt_clr;
    logic [CW-1:0]      cnt_d;
    logic               cnt_term;
    logic [WW-1:0]      word_in;
    logic               cur_store;
    logic [WW-1:0]      cur_word;
    logic [31:0]        cur_st;
    logic               active_d;
    logic               hi_d;

    assign req     = MEM_R_En | MEM_W_En;
    assign in_half = (state_q == ST_LO) || (state_q == ST_HI);
    assign word_in = WW'(word_offset(ALU_result, ADDR_BASE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_LO;
            ST_LO:   if (cnt_term) state_d = ST_HI;
            ST_HI:   if (cnt_term) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_clr = (state_d != state_q) || !in_half;

    sram_wait_cnt #(
        .MAX_VAL (WAIT_CYCLES),
        .CW      (CW)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (in_half),
        .cnt_d (cnt_d),
        .term  (cnt_term)
    );

    // Operation is captured at launch so a flushed request still finishes cleanly.
    always_comb begin
        op_store_d = op_store_q;
        word_d     = word_q;
        st_val_d   = st_val_q;
        if (state_q == ST_IDLE && req) begin
            op_store_d = MEM_W_En;
            word_d     = word_in;
            st_val_d   = ST_val;
        end
    end

    assign cur_store = (state_q == ST_IDLE) ? MEM_W_En : op_store_q;
    assign cur_word  = (state_q == ST_IDLE) ? word_in  : word_q;
    assign cur_st    = (state_q == ST_IDLE) ? ST_val   : st_val_q;
    assign active_d  = (state_d == ST_LO) || (state_d == ST_HI);
    assign hi_d      = (state_d == ST_HI);

    // Bus outputs are registered from next-state so they are valid for the whole half.
    always_comb begin
        addr_d = addr_q;
        dq_o_d = dq_o_q;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (active_d) begin
            addr_d = {cur_word, hi_d};
            if (cur_store) begin
                oe_d   = 1'b1;
                dq_o_d = hi_d ? cur_st[31:16] : cur_st[15:0];
                we_n_d = (cnt_d == WAIT_C);
            end
        end
    end

    // The low half is staged so read_data only changes when the whole word is in.
    always_comb begin
        lo_buf_d    = lo_buf_q;
        read_data_d = read_data_q;
        if (cnt_term && !op_store_q) begin
            if (state_q == ST_LO) begin
                lo_buf_d = SRAM_DQ_i;
            end else if (state_q == ST_HI) begin
                read_data_d = {SRAM_DQ_i, lo_buf_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_store_q  <= 1'b0;
            word_q      <= '0;
            st_val_q    <= '0;
            lo_buf_q    <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            dq_o_q      <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_store_q  <= op_store_d;
            word_q      <= word_d;
            st_val_q    <= st_val_d;
            lo_buf_q    <= lo_buf_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready      = !req || (state_q == ST_DONE);
    assign read_data  = read_data_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_DQ_o  = dq_o_q;
    assign SRAM_DQ_oe = oe_q;
    assign SRAM_WE_N  = we_n_q;

endmodule
